// File: rtl/traffic_countdown_bcd.sv
// Two-digit BCD countdown timer for one traffic-light phase.
// It loads a duration, steps down once per prescaled tick, and pulses done one cycle after reaching 00.
module traffic_countdown_bcd #(
  parameter int TICK_DIV = 50000000,
  parameter int PRESC_W  = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       run,
  output logic [3:0] tens_bcd,
  output logic [3:0] ones_bcd,
  output logic       tick,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         clamp_tens, clamp_ones;
  logic               step;

  always_comb begin
    clamp_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;
    clamp_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;
    step       = (state_q == COUNT) && run && (presc_q == PRESC_W'(TICK_DIV - 1));

    state_d = state_q;
    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    tick_d  = 1'b0;
    // busy and done trail the state by one cycle, so done lands the
    // cycle after the final tick and busy drops together with it.
    busy_d  = (state_q == COUNT);
    done_d  = (state_q == EXPIRE);

    if (load) begin
      tens_d  = clamp_tens;
      ones_d  = clamp_ones;
      presc_d = '0;
      state_d = (clamp_tens == 4'd0 && clamp_ones == 4'd0) ? EXPIRE : COUNT;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
        end
        COUNT: begin
          if (run) begin
            if (step) begin
              presc_d = '0;
              tick_d  = 1'b1;
              if (tens_q == 4'd0 && ones_q <= 4'd1) begin
                // Final step (01 -> 00); never wrap below zero.
                ones_d  = 4'd0;
                state_d = EXPIRE;
              end else if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end
            end else begin
              presc_d = presc_q + PRESC_W'(1);
            end
          end
        end
        EXPIRE: begin
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tens_bcd = tens_q;
  assign ones_bcd = ones_q;
  assign tick     = tick_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/traffic_countdown_bcd.md
Name: traffic_countdown_bcd

Overview:
- Per-phase countdown timer for the traffic light controller.
- Loads a two-digit BCD duration, decrements once per prescaled second tick, and raises a one-cycle done pulse at 00.
- Sits directly upstream of the BCD-to-seven-segment decoders: tens_bcd and ones_bcd each drive one decoder input.
- The controller FSM issues load and consumes done to advance the light phase.

Parameters:
- TICK_DIV, 50000000: clock cycles per countdown step (1 s at 50 MHz); must be >= 2; benches use 4.
- PRESC_W, 26: prescaler width; must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  capture load_tens/load_ones and start counting.
- load_tens  input  4  BCD tens digit of duration.
- load_ones  input  4  BCD ones digit of duration.
- run  input  1  1 = prescaler advances; 0 = pause (hold everything).
- tens_bcd  output  4  current tens digit, 0..9.
- ones_bcd  output  4  current ones digit, 0..9.
- tick  output  1  one-cycle pulse on each countdown step.
- busy  output  1  high while in COUNT.
- done  output  1  one-cycle pulse when count reaches 00.

Behaviour:
- One clock domain, clk. Reset is synchronous, active-high on rst and has priority over all inputs.
- Reset values: tens_bcd=0, ones_bcd=0, tick=0, busy=0, done=0, prescaler=0, state=IDLE.
- All outputs are registered.
- States: IDLE, COUNT, EXPIRE.
- load (any state, highest priority after rst):
  - Digits register on that edge. Any digit >9 is clamped to 9.
  - Prescaler clears to 0.
  - If the loaded value is nonzero: next state COUNT, busy=1 from the following cycle.
  - If the loaded value is 00: next state EXPIRE.
  - A load in the same cycle as a step cancels that step; no decrement and no tick.
- IDLE:
  - Digits hold; busy=0; prescaler held at 0; run is ignored.
- COUNT:
  - run=1: prescaler increments each cycle.
  - run=0: prescaler, digits and state all hold.
  - Step condition: prescaler==TICK_DIV-1 and run=1. On a step, prescaler goes to 0, tick=1 for one cycle, and the BCD value decrements.
  - Decrement rule: if ones>0, ones-1; else ones=9 and tens-1.
  - If the pre-step value is 01, the result is 00 and next state is EXPIRE.
- EXPIRE:
  - done=1 for exactly this one cycle; busy=0; digits hold 00.
  - Next state is IDLE unless load is asserted.
- Latency:
  - First tick occurs TICK_DIV run-cycles after the load edge.
  - A count of N reaches 00 after N*TICK_DIV run-cycles.
  - done is asserted on the cycle after the final tick.
- Display never wraps below 00 and never shows a non-BCD digit.
- Reset mid-count: the next edge returns to the reset values; done is not issued.

Test Plan:
1. TICK_DIV=4, rst 2 cycles, then idle → tens=0, ones=0, busy=0, done=0, tick never pulses.
2. load tens=1 ones=2, run=1 held → sequence 12, 11, 10, 09, ..., 01, 00 with a tick every 4 cycles. 10→09 borrow is correct. done pulses once, one cycle after the 01→00 tick. busy falls with done.
3. load 0/5, run=1 for 6 cycles, run=0 for 10 cycles, then run=1 → value 04 holds through the pause. The prescaler resumes from its held count, so the next tick is 2 cycles after run returns.
4. load 0/0 → digits 00, done=1 on the next cycle, busy stays 0. Also load 0xF/0xA → digits 9/9.
5. Mid-count at 03, assert load 2/0 coincident with a step → no tick that cycle. Digits become 20, prescaler 0, counting restarts.
6. Mid-count at 07, assert rst for 1 cycle → 00, busy=0, no done pulse. With rst and load in the same cycle, reset wins.
